// File: rtl/tmr_alu_health_monitor_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tmr_health_pkg: shared types and blame classification for TMR monitor |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package tmr_health_pkg;

  localparam int CONSEC_W = 4;

  typedef enum logic [1:0] {
    HS_OK       = 2'b00,
    HS_DEGRADED = 2'b01,
    HS_FAILED   = 2'b10
  } health_t;

  typedef enum logic [2:0] {
    BL_NONE,
    BL_ALU1,
    BL_ALU2,
    BL_ALU3,
    BL_TRIPLE
  } blame_t;

  // The replica left out of the only matching pair is the one blamed.
  // Two matching pairs cannot happen with a real comparator, so it is treated as triple.
  function automatic blame_t classify_blame(input logic m12, input logic m13, input logic m23);
    case ({m12, m13, m23})
      3'b111:  classify_blame = BL_NONE;
      3'b100:  classify_blame = BL_ALU3;
      3'b010:  classify_blame = BL_ALU2;
      3'b001:  classify_blame = BL_ALU1;
      default: classify_blame = BL_TRIPLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_alu_health_monitor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tmr_alu_health_monitor_if: match flags, clears and health outputs     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface tmr_alu_health_monitor_if #(
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic             alu1_alu2_match;
  logic             alu1_alu3_match;
  logic             alu2_alu3_match;
  logic             clear_stats;
  logic             clear_faults;
  logic [2:0]       fault_mask;
  logic [1:0]       health_state;
  logic [CNT_W-1:0] err_cnt1;
  logic [CNT_W-1:0] err_cnt2;
  logic [CNT_W-1:0] err_cnt3;
  logic             uncorrectable;
  logic             irq;

  modport master (
    output sample_valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match,
    output clear_stats, clear_faults,
    input  fault_mask, health_state, err_cnt1, err_cnt2, err_cnt3,
    input  uncorrectable, irq
  );

  modport slave (
    input  sample_valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match,
    input  clear_stats, clear_faults,
    output fault_mask, health_state, err_cnt1, err_cnt2, err_cnt3,
    output uncorrectable, irq
  );
endinterface
`default_nettype wire

// File: rtl/tmr_alu_health_monitor_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tmr_replica_err_tracker: total/consecutive counters and fault flag    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tmr_replica_err_tracker
  import tmr_health_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int PERM_THRESH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             sample_i,
  input  wire logic             blamed_i,
  input  wire logic             clear_stats_i,
  input  wire logic             clear_faults_i,
  output logic      [CNT_W-1:0] total_o,
  output logic                  fault_o,
  output logic                  fault_next_o
);

  localparam logic [CNT_W-1:0]    TOTAL_MAX = '1;
  localparam logic [CONSEC_W-1:0] THRESH    = CONSEC_W'(PERM_THRESH);

  logic [CNT_W-1:0]    total_q, total_d;
  logic [CONSEC_W-1:0] consec_q, consec_d, consec_inc_w;
  logic                fault_q, fault_d, fault_set_w;

  always_comb begin
    total_d      = total_q;
    consec_d     = consec_q;
    consec_inc_w = (consec_q >= THRESH) ? THRESH : consec_q + CONSEC_W'(1);
    // The fault decision uses the incremented value even when a stats clear drops it.
    fault_set_w  = sample_i && blamed_i && (consec_inc_w == THRESH);
    if (sample_i) begin
      if (blamed_i) begin
        total_d  = (total_q == TOTAL_MAX) ? total_q : total_q + CNT_W'(1);
        consec_d = consec_inc_w;
      end else begin
        consec_d = '0;
      end
    end
    if (clear_stats_i) begin
      total_d  = '0;
      consec_d = '0;
    end
    fault_d = clear_faults_i ? 1'b0 : (fault_q | fault_set_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q  <= '0;
      consec_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      total_q  <= total_d;
      consec_q <= consec_d;
      fault_q  <= fault_d;
    end
  end

  assign total_o      = total_q;
  assign fault_o      = fault_q;
  assign fault_next_o = fault_d;

endmodule
`default_nettype wire

// File: rtl/tmr_alu_health_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tmr_alu_health_monitor: classifies TMR disagreements, drives health   |
// | FSM, uncorrectable pulse and irq.  Rev 1.0                            |
// +-----------------------------------------------------------------------+
module tmr_alu_health_monitor
  import tmr_health_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int PERM_THRESH = 4
) (
  input wire logic                clk,
  input wire logic                reset,
  tmr_alu_health_monitor_if.slave bus
);

  health_t          state_q, state_d;
  logic             uncorr_q, uncorr_d;
  logic             irq_q, irq_d;
  blame_t           blame_w;
  logic [2:0]       blamed_w;
  logic [2:0]       fault_mask_w;
  logic [2:0]       fault_next_w;
  logic [CNT_W-1:0] cnt_w [3];
  logic             healthy_pair_w;
  logic             uncorr_evt_w;
  logic [1:0]       pop_next_w;

  assign blame_w = bus.sample_valid
                 ? classify_blame(bus.alu1_alu2_match, bus.alu1_alu3_match, bus.alu2_alu3_match)
                 : BL_NONE;

  assign blamed_w[0] = (blame_w == BL_ALU1);
  assign blamed_w[1] = (blame_w == BL_ALU2);
  assign blamed_w[2] = (blame_w == BL_ALU3);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_tracker
      tmr_replica_err_tracker #(
        .CNT_W       (CNT_W),
        .PERM_THRESH (PERM_THRESH)
      ) u_tracker (
        .clk            (clk),
        .reset          (reset),
        .sample_i       (bus.sample_valid),
        .blamed_i       (blamed_w[gi]),
        .clear_stats_i  (bus.clear_stats),
        .clear_faults_i (bus.clear_faults),
        .total_o        (cnt_w[gi]),
        .fault_o        (fault_mask_w[gi]),
        .fault_next_o   (fault_next_w[gi])
      );
    end
  endgenerate

  assign pop_next_w = 2'(fault_next_w[0]) + 2'(fault_next_w[1]) + 2'(fault_next_w[2]);

  // With one replica out, only the pair formed by the other two still matters.
  always_comb begin
    healthy_pair_w = 1'b0;
    case (fault_mask_w)
      3'b100:  healthy_pair_w = bus.alu1_alu2_match;
      3'b010:  healthy_pair_w = bus.alu1_alu3_match;
      3'b001:  healthy_pair_w = bus.alu2_alu3_match;
      default: healthy_pair_w = 1'b0;
    endcase
  end

  always_comb begin
    uncorr_evt_w = 1'b0;
    if (bus.sample_valid) begin
      if (state_q == HS_DEGRADED) uncorr_evt_w = !healthy_pair_w;
      else                        uncorr_evt_w = (blame_w == BL_TRIPLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HS_OK;
      uncorr_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      uncorr_q <= uncorr_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear_faults) begin
      state_d = HS_OK;
    end else begin
      case (state_q)
        HS_OK: begin
          if (pop_next_w >= 2'd2 || uncorr_evt_w) state_d = HS_FAILED;
          else if (pop_next_w == 2'd1)            state_d = HS_DEGRADED;
        end
        HS_DEGRADED: begin
          if (pop_next_w >= 2'd2 || uncorr_evt_w) state_d = HS_FAILED;
        end
        HS_FAILED: state_d = HS_FAILED;
        default:   state_d = HS_FAILED;
      endcase
    end
  end

  always_comb begin
    uncorr_d = uncorr_evt_w;
    irq_d    = irq_q | uncorr_evt_w | ((state_q == HS_OK) && (state_d != HS_OK));
    if (bus.clear_faults) irq_d = 1'b0;
  end

  assign bus.fault_mask    = fault_mask_w;
  assign bus.health_state  = state_q;
  assign bus.err_cnt1      = cnt_w[0];
  assign bus.err_cnt2      = cnt_w[1];
  assign bus.err_cnt3      = cnt_w[2];
  assign bus.uncorrectable = uncorr_q;
  assign bus.irq           = irq_q;

endmodule
`default_nettype wire

// File: doc/tmr_alu_health_monitor.md
Name: tmr_alu_health_monitor

Overview:
- Sequential fault manager for the triple-redundant ALU.
- Samples the three pairwise match flags on every qualified ALU operation and classifies which replica, if any, disagreed.
- Keeps per-replica error statistics and declares a replica permanently faulty after consecutive disagreements.
- Drives a health state machine (OK/DEGRADED/FAILED) and an interrupt toward the processor's control/CSR logic.

Parameters:
- CNT_W, 16, width of each saturating per-replica total-error counter
- PERM_THRESH, 4, consecutive disagreements (1..15) that mark a replica permanently faulty

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  ALU result is architecturally consumed this cycle; match flags are meaningful
- alu1_alu2_match  in  1  replica 1 and 2 results equal
- alu1_alu3_match  in  1  replica 1 and 3 results equal
- alu2_alu3_match  in  1  replica 2 and 3 results equal
- clear_stats  in  1  pulse: zero all total and consecutive counters
- clear_faults  in  1  pulse: clear fault_mask and sticky FAILED, return to OK
- fault_mask  out  3  bit i-1 set = replica i permanently faulty (sticky)
- health_state  out  2  OK / DEGRADED / FAILED
- err_cnt1, err_cnt2, err_cnt3  out  CNT_W  saturating total disagreements per replica
- uncorrectable  out  1  one-cycle pulse on an event the voter cannot resolve
- irq  out  1  level; set on any health_state transition away from OK or on uncorrectable; cleared by clear_faults

Behaviour:
- Reset values: fault_mask=0, health_state=OK, all counters 0, uncorrectable=0, irq=0.
- All outputs are registered and reflect a sample one cycle after sample_valid.
- Classification, only when sample_valid=1:
  - all three match → clean
  - only 1-2 match → replica 3 bad
  - only 1-3 match → replica 2 bad
  - only 2-3 match → replica 1 bad
  - no pair matches → triple disagreement
  - exactly two pairs matching is logically impossible; treat it as triple disagreement
- Per replica on a sample:
  - If bad: total count +1, saturating at 2^CNT_W-1; consecutive count +1, saturating at PERM_THRESH.
  - If not blamed: consecutive count resets to 0.
  - Triple disagreement increments no counters.
- When a replica's consecutive count reaches PERM_THRESH, set its fault_mask bit in that same update. The bit is sticky.
- A replica already in fault_mask still accumulates its total count.
- FSM:
  - OK → DEGRADED when popcount(next fault_mask)=1.
  - OK or DEGRADED → FAILED when popcount≥2 or on an uncorrectable event.
  - DEGRADED stays DEGRADED on faulty-replica disagreements.
  - FAILED is sticky. Only clear_faults or reset leave it; clear_faults returns to OK.
- Uncorrectable event:
  - In OK: triple disagreement.
  - In DEGRADED: the two healthy replicas' pair flag is 0, regardless of the faulty replica.
  - In FAILED: uncorrectable still pulses on triple disagreement; the state is unchanged.
- sample_valid=0: no counter, mask or state change.
- Simultaneous events:
  - clear_stats with a sample: clear wins; counters become 0 and the sample's increments are dropped. The mask and FSM still update from the sample.
  - clear_faults with a sample: clear wins for mask, state and irq; the sample's counter updates still apply.
  - Both clears together: both take effect.
- Reset asserted mid-operation returns everything to its reset values immediately (asynchronous).

Decomposition:
- Package tmr_health_pkg holds:
  - health_t enum {HS_OK=2'b00, HS_DEGRADED=2'b01, HS_FAILED=2'b10}
  - the blame-classification enum {BL_NONE, BL_ALU1, BL_ALU2, BL_ALU3, BL_TRIPLE}
  - a function mapping the three match flags to a blame value
- One sub-module, tmr_replica_err_tracker, instantiated 3×. It holds the total counter, consecutive counter and permanent-fault flag for one replica.
- The top level holds classification, the FSM, the uncorrectable pulse and irq.

Test Plan:
- Reset, then 10 samples with all flags=1 → counters stay 0, health_state=OK, irq=0.
- Four consecutive samples with (1,0,0), PERM_THRESH=4:
  - err_cnt3=4.
  - fault_mask=3'b100 one cycle after the 4th sample.
  - health_state=DEGRADED, irq=1.
- Replica-2 blamed 3×, then one clean sample, then blamed 3× → err_cnt2=6, consecutive count reset, fault_mask=0, health_state=OK.
- In DEGRADED with replica 3 faulty, a sample with alu1_alu2_match=0 → uncorrectable pulses for exactly 1 cycle and health_state=FAILED. Then clear_faults → OK, fault_mask=0, irq=0, counters retained.
- Preload err_cnt1 to 2^CNT_W-1 (CNT_W=4, 15 blames), then blame again → err_cnt1 stays 15.
- clear_stats on the same cycle as a replica-1 blame → err_cnt1=0 and the consecutive count is 0 next cycle. Reset asserted mid-sequence → all outputs 0/OK without waiting for a clock edge.
